// File: rtl/cache_2way_write_through.sv
// Single-cycle 2-way set-associative write-through / write-allocate cache with LRU
// replacement, fronting a word-organised main memory that refills a whole block per cycle.

module cache_mem #(
   parameter int DATA_W          = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int MEM_WORDS       = 256
) (
   input  logic                                         clk,
   input  logic                                         rst,
   input  logic                                         we,
   input  logic [$clog2(MEM_WORDS)-1:0]                 waddr,
   input  logic [DATA_W-1:0]                            wdata,
   input  logic [$clog2(MEM_WORDS)-$clog2(WORDS_PER_BLOCK)-1:0] blk_addr,
   output logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0]       rblock
);
   localparam int OFF_W = $clog2(WORDS_PER_BLOCK);

   logic [DATA_W-1:0] mem [0:MEM_WORDS-1];

   // Whole-block combinational read so a refill completes in the access cycle
   always_comb begin
      rblock = '0;
      for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
         rblock[i] = mem[{blk_addr, OFF_W'(i)}];
      end
   end

   // Memory array: cleared on reset, single write port
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < MEM_WORDS; i++) begin
            mem[i] <= '0;
         end
      end else if (we) begin
         mem[waddr] <= wdata;
      end
   end
endmodule

module cache_2way_write_through #(
   parameter int ADDR_W          = 10,
   parameter int DATA_W          = 32,
   parameter int WORDS_PER_BLOCK = 4,
   parameter int NUM_SETS        = 2,
   parameter int MEM_WORDS       = 256
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req,
   input  logic              read_write,
   input  logic [ADDR_W-1:0] address,
   input  logic [DATA_W-1:0] write_data,
   output logic [DATA_W-1:0] read_data,
   output logic              hit_miss,
   output logic              done
);
   localparam int OFF_W = $clog2(WORDS_PER_BLOCK);
   localparam int IDX_W = $clog2(NUM_SETS);
   localparam int TAG_W = ADDR_W - 2 - OFF_W - IDX_W;
   localparam int MEM_AW = $clog2(MEM_WORDS);
   localparam int BLK_W = MEM_AW - OFF_W;

   logic                                   valid_r [NUM_SETS][2];
   logic [TAG_W-1:0]                       tag_r   [NUM_SETS][2];
   logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] data_r  [NUM_SETS][2];
   logic                                   lru_r   [NUM_SETS];

   logic [TAG_W-1:0]                       tag_s;
   logic [IDX_W-1:0]                       idx_s;
   logic [OFF_W-1:0]                       off_s;
   logic [MEM_AW-1:0]                      widx_s;
   logic [1:0]                             unused_byte_s;
   logic                                   hit0_s;
   logic                                   hit1_s;
   logic                                   hit_s;
   logic                                   way_s;
   logic                                   mem_we_s;
   logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] rblock_s;
   logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] line_s;
   logic [WORDS_PER_BLOCK-1:0][DATA_W-1:0] new_line_s;
   logic [DATA_W-1:0]                      result_s;

   assign tag_s         = address[ADDR_W-1 -: TAG_W];
   assign idx_s         = address[2+OFF_W +: IDX_W];
   assign off_s         = address[2 +: OFF_W];
   assign widx_s        = address[ADDR_W-1:2];
   assign unused_byte_s = address[1:0];
   assign mem_we_s      = req && read_write && !rst;

   cache_mem #(
      .DATA_W          (DATA_W),
      .WORDS_PER_BLOCK (WORDS_PER_BLOCK),
      .MEM_WORDS       (MEM_WORDS)
   ) main_mem (
      .clk      (clk),
      .rst      (rst),
      .we       (mem_we_s),
      .waddr    (widx_s),
      .wdata    (write_data),
      .blk_addr (widx_s[MEM_AW-1 -: BLK_W]),
      .rblock   (rblock_s)
   );

   // Tag match and way selection: hit way, else first invalid way, else LRU way
   always_comb begin
      hit0_s = valid_r[idx_s][0] && (tag_r[idx_s][0] == tag_s);
      hit1_s = valid_r[idx_s][1] && (tag_r[idx_s][1] == tag_s);
      hit_s  = hit0_s || hit1_s;
      if (hit0_s) begin
         way_s = 1'b0;
      end else if (hit1_s) begin
         way_s = 1'b1;
      end else if (!valid_r[idx_s][0]) begin
         way_s = 1'b0;
      end else if (!valid_r[idx_s][1]) begin
         way_s = 1'b1;
      end else begin
         way_s = lru_r[idx_s];
      end
   end

   // Source line (cached or refilled from memory) with store data merged in
   always_comb begin
      if (hit_s) begin
         line_s = data_r[idx_s][way_s];
      end else begin
         line_s = rblock_s;
      end
      new_line_s = line_s;
      if (read_write) begin
         new_line_s[off_s] = write_data;
         result_s          = write_data;
      end else begin
         result_s          = line_s[off_s];
      end
   end

   // Cache state and registered result
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NUM_SETS; s++) begin
            valid_r[s][0] <= 1'b0;
            valid_r[s][1] <= 1'b0;
            lru_r[s]      <= 1'b0;
         end
         read_data <= '0;
         hit_miss  <= 1'b0;
         done      <= 1'b0;
      end else if (req) begin
         valid_r[idx_s][way_s] <= 1'b1;
         tag_r[idx_s][way_s]   <= tag_s;
         data_r[idx_s][way_s]  <= new_line_s;
         lru_r[idx_s]          <= ~way_s;
         read_data             <= result_s;
         hit_miss              <= hit_s;
         done                  <= 1'b1;
      end else begin
         done <= 1'b0;
      end
   end
endmodule

// File: tb/tb_cache_2way_write_through.sv
// Directed bench: expected results are queued at issue time and checked by a monitor on done.

module tb_cache_2way_write_through;
   logic        clk = 1'b0;
   logic        rst;
   logic        req;
   logic        read_write;
   logic [9:0]  address;
   logic [31:0] write_data;
   logic [31:0] read_data;
   logic        hit_miss;
   logic        done;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [31:0] rd;
      logic        hm;
      logic [9:0]  addr;
   } exp_t;

   exp_t exp_q[$];

   cache_2way_write_through dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .read_write (read_write),
      .address    (address),
      .write_data (write_data),
      .read_data  (read_data),
      .hit_miss   (hit_miss),
      .done       (done)
   );

   always #5 clk = ~clk;

   // Monitor: every done pulse must match the oldest outstanding expectation
   always @(negedge clk) begin
      if (done) begin
         checks++;
         if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL spurious_done: done=1 with no outstanding request");
         end else begin
            exp_t e;
            e = exp_q.pop_front();
            if (read_data !== e.rd || hit_miss !== e.hm) begin
               errors++;
               $display("FAIL access_%03h: got data=%08h hit=%b, expected data=%08h hit=%b",
                        e.addr, read_data, hit_miss, e.rd, e.hm);
            end
         end
      end
   end

   task automatic access(input logic rw, input logic [9:0] a, input logic [31:0] wd,
                         input logic [31:0] exp_rd, input logic exp_hm);
      exp_t e;
      e.rd = exp_rd; e.hm = exp_hm; e.addr = a;
      exp_q.push_back(e);
      req = 1'b1; read_write = rw; address = a; write_data = wd;
      @(posedge clk); #1;
      req = 1'b0;
   endtask

   task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h, expected %08h", name, act, exp);
      end
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic drain();
      int budget;
      budget = 20;
      while (exp_q.size() != 0 && budget > 0) begin
         @(posedge clk); #1;
         budget--;
      end
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d responses outstanding, expected 0", exp_q.size());
      end
   endtask

   initial begin
      rst = 1'b1; req = 1'b1; read_write = 1'b0; address = 10'h000; write_data = 32'h0;
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      check_val("reset_read_data", read_data, 32'h0000_0000);
      check_val("reset_hit_miss", {31'd0, hit_miss}, 32'd0);
      check_val("reset_done", {31'd0, done}, 32'd0);
      idle(1);

      // Set 0: fill, write-through hit, two-way retention, LRU eviction
      access(1'b0, 10'h000, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b1, 10'h000, 32'h0000_00FF, 32'h0000_00FF, 1'b1);
      check_val("mem0_after_write", dut.main_mem.mem[0], 32'h0000_00FF);
      access(1'b0, 10'h000, 32'h0, 32'h0000_00FF, 1'b1);
      access(1'b0, 10'h200, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b0, 10'h000, 32'h0, 32'h0000_00FF, 1'b1);
      access(1'b0, 10'h300, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b0, 10'h200, 32'h0, 32'h0000_0000, 1'b0);
      check_val("mem0_after_evict", dut.main_mem.mem[0], 32'h0000_00FF);
      access(1'b0, 10'h300, 32'h0, 32'h0000_0000, 1'b1);
      access(1'b0, 10'h000, 32'h0, 32'h0000_00FF, 1'b0);

      // Write miss allocates the block and writes memory
      access(1'b1, 10'h024, 32'h1234_5678, 32'h1234_5678, 1'b0);
      check_val("mem9_write_miss", dut.main_mem.mem[9], 32'h1234_5678);
      access(1'b0, 10'h024, 32'h0, 32'h1234_5678, 1'b1);
      access(1'b0, 10'h020, 32'h0, 32'h0000_0000, 1'b1);
      access(1'b0, 10'h02F, 32'h0, 32'h0000_0000, 1'b1);

      // Set 1 operates independently
      access(1'b1, 10'h010, 32'hAABB_CCDD, 32'hAABB_CCDD, 1'b0);
      check_val("mem4_write_miss", dut.main_mem.mem[4], 32'hAABB_CCDD);
      access(1'b0, 10'h01C, 32'h0, 32'h0000_0000, 1'b1);
      access(1'b1, 10'h01C, 32'h0000_0055, 32'h0000_0055, 1'b1);
      check_val("mem7_write_hit", dut.main_mem.mem[7], 32'h0000_0055);
      access(1'b0, 10'h210, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b0, 10'h310, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b0, 10'h010, 32'h0, 32'hAABB_CCDD, 1'b0);
      access(1'b0, 10'h01C, 32'h0, 32'h0000_0055, 1'b1);
      access(1'b0, 10'h024, 32'h0, 32'h1234_5678, 1'b1);

      // Idle: outputs hold and no extra done pulses
      idle(3);
      check_val("hold_read_data", read_data, 32'h1234_5678);
      check_val("hold_hit_miss", {31'd0, hit_miss}, 32'd1);
      check_val("idle_done", {31'd0, done}, 32'd0);
      drain();

      // Mid-sequence reset with a simultaneous request
      rst = 1'b1; req = 1'b1; read_write = 1'b1; address = 10'h010; write_data = 32'hDEAD_BEEF;
      @(posedge clk); #1;
      rst = 1'b0; req = 1'b0;
      check_val("rst_read_data", read_data, 32'h0000_0000);
      check_val("rst_hit_miss", {31'd0, hit_miss}, 32'd0);
      check_val("rst_mem4", dut.main_mem.mem[4], 32'h0000_0000);
      check_val("rst_mem9", dut.main_mem.mem[9], 32'h0000_0000);
      access(1'b0, 10'h010, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b0, 10'h024, 32'h0, 32'h0000_0000, 1'b0);
      access(1'b0, 10'h010, 32'h0, 32'h0000_0000, 1'b1);
      idle(2);
      drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
